// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants: active-low patterns, bit 0 = segment A .. bit 6 = segment G.
// The same table drives the hex-to-segment decoder, so encode and decode cannot drift apart.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_pattern_to_hex.sv
// Combinational reverse lookup: active-low segment pattern to hex value, with legal and blank flags.
module seven_seg_pattern_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] hex,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        hex   = '0;
        legal = 1'b0;
        blank = (pattern == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_HEX[i]) begin
                hex   = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Reads a multiplexed common-anode seven-segment bus back into per-digit hex values.
// Inputs are synchronised and must hold for STABLE_CYCLES samples before one capture per run.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en_n,
    output logic [4*NUM_DIGITS-1:0] hex_flat,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd_valid,
    output logic [2:0]              upd_idx,
    output logic [3:0]              upd_hex,
    output logic                    upd_err,
    output logic                    upd_blank
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NUM_DIGITS + 7;

    // {dig_en_n, seg}; the idle value (no digit, all segments off) is all ones
    logic [SW-1:0] sync1, sync2, sample;
    logic [CW-1:0] cnt;
    logic          armed;

    logic [NUM_DIGITS-1:0] en_n;
    logic [NUM_DIGITS-1:0] sel;
    logic [6:0]            pat;
    logic [3:0]            n_low;
    logic [2:0]            idx;
    logic [3:0]            dec_hex;
    logic                  dec_legal;
    logic                  dec_blank;
    logic                  capture;

    // Capture data comes from the sample register: it is the value the counter has been counting.
    assign en_n = sample[SW-1:7];
    assign pat  = sample[6:0];
    assign sel  = ~en_n;

    always_comb begin
        n_low = '0;
        idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!en_n[i]) begin
                n_low = n_low + 4'd1;
                idx   = 3'(i);
            end
        end
    end

    assign capture = (cnt == CW'(STABLE_CYCLES)) && armed && (n_low == 4'd1);

    seven_seg_pattern_to_hex u_decode (
        .pattern (pat),
        .hex     (dec_hex),
        .legal   (dec_legal),
        .blank   (dec_blank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            sync2  <= '1;
            sample <= '1;
            cnt    <= '0;
            armed  <= 1'b1;
        end else begin
            sync1  <= {dig_en_n, seg};
            sync2  <= sync1;
            sample <= sync2;
            if (sync2 != sample) begin
                cnt   <= CW'(1);
                armed <= 1'b1;
            end else begin
                if (cnt < CW'(STABLE_CYCLES)) begin
                    cnt <= cnt + 1'b1;
                end
                if (capture) begin
                    armed <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_flat    <= '0;
            digit_valid <= '0;
            upd_valid   <= 1'b0;
            upd_idx     <= '0;
            upd_hex     <= '0;
            upd_err     <= 1'b0;
            upd_blank   <= 1'b0;
        end else begin
            upd_valid <= capture;
            if (capture) begin
                upd_idx   <= idx;
                upd_hex   <= dec_legal ? dec_hex : 4'h0;
                upd_err   <= !dec_legal && !dec_blank;
                upd_blank <= dec_blank;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        digit_valid[i] <= dec_legal;
                        if (dec_legal) begin
                            hex_flat[4*i +: 4] <= dec_hex;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Recovers hex digits from a multiplexed, common-anode seven-segment display bus: segment lines plus per-digit enables.
- Works in the opposite direction to our hex-to-segment decoder.
- Sits beside the scoreboard display path as a self-check and loopback monitor, and can read external score displays.
- Synchronises the inputs, requires the pattern to be stable before capture, converts the pattern back to a 4-bit value, stores one value per digit, and flags illegal patterns.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical synced samples required before capture (>=1).

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- seg  input  7  segment lines, active-low; seg[0]=A, seg[1]=B ... seg[6]=G; asynchronous to clk.
- dig_en_n  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i; asynchronous to clk.
- hex_flat  output  4*NUM_DIGITS  stored value; digit i is in bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  digit i holds a legal, non-blank capture.
- upd_valid  output  1  one-cycle pulse, capture event.
- upd_idx  output  3  digit index of the capture.
- upd_hex  output  4  captured value (0 when err or blank).
- upd_err  output  1  captured pattern is illegal.
- upd_blank  output  1  captured pattern has all segments off.

Behaviour:
- Reset, asynchronous on rst_n low:
  - hex_flat=0, digit_valid=0, upd_* all 0.
  - Sync flops load seg=7'h7F, dig_en_n=all ones.
  - Stability counter=0, armed=1.
- Synchronisation: seg and dig_en_n pass through a 2-flop synchroniser. A further sample register holds the previous synced value for comparison.
- Stability counter:
  - Width $clog2(STABLE_CYCLES+1); saturates at STABLE_CYCLES.
  - When the synced {dig_en_n, seg} differs from the previous sample, the counter is set to 1 and armed is set to 1.
  - When equal and the counter is below STABLE_CYCLES, the counter increments.
- Capture condition: counter reaches STABLE_CYCLES && armed && exactly one dig_en_n bit low. On capture, armed clears, so there is exactly one capture per stable run.
- Capture effects, all registered; upd_valid is high for exactly one cycle:
  - upd_idx = index of the low enable bit.
  - Legal pattern: upd_hex=value, hex_flat[digit]=value, digit_valid[digit]=1.
  - Blank pattern: upd_blank=1, upd_hex=0, digit_valid[digit]=0, hex_flat[digit] keeps its old value.
  - Any other pattern: upd_err=1, upd_hex=0, digit_valid[digit]=0, hex_flat[digit] keeps its old value.
- Latency: a new input held steady from edge N produces upd_valid high in the cycle after edge N+2+STABLE_CYCLES.
- Zero or more than one enable low: no capture. The counter still tracks stability, and armed remains set. If the enables later change to a legal one-hot value, that is a change, so the run restarts.
- Glitch shorter than STABLE_CYCLES synced samples: no capture. A return to the earlier value counts as a change and restarts the run; that value is captured again after STABLE_CYCLES samples.
- Lit-segment sets that count as legal:
  - 0=ABCDEF, 1=BC, 2=ABDEG, 3=ABCDG, 4=BCFG, 5=ACDFG, 6=ACDEFG, 7=ABC.
  - 8=ABCDEFG, 9=ABCDFG, A=ABCEFG, b=CDEFG, C=ADEF, d=BCDEG, E=ADEFG, F=AEFG.
  - Every other pattern is illegal.
- Digit indices >= NUM_DIGITS cannot occur; upd_idx upper bits are 0.
- Reset asserted mid-run: immediate return to reset values. No upd_valid is produced until a full new stable run completes after release.

Decomposition:
- Shared package seven_seg_pkg holds:
  - the 16 segment-pattern constants (active-low, bit order A..G), shared with the existing decoder;
  - SEG_BLANK = 7'h7F.
- One combinational sub-module, seven_seg_pattern_to_hex:
  - input: 7-bit pattern;
  - outputs: hex[3:0], legal, blank.
  - Implemented as a lookup against the package constants; verified exhaustively against the existing decoder.
- The top level contains the synchroniser, the stability counter, the one-hot check and the per-digit registers.

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> all outputs 0. Release and apply no stimulus for 20 cycles -> no upd_valid.
- Legal capture: dig_en_n=4'b1110, seg=7'h24 (digit 2), held 10 cycles -> exactly one upd_valid, 7 cycles after the first edge; upd_idx=0, upd_hex=2, hex_flat[3:0]=2, digit_valid=4'b0001.
- Exhaustive loopback: drive the existing decoder with values 0..15 across digits 0..3, changing every 8 cycles -> 64 captures, each upd_hex matching the driven value, upd_err=0.
- Glitch filter: with digit 1 showing 'A' (7'h08), insert a 2-cycle seg=7'h00 -> no capture of 8; a recapture of 'A' (upd_hex=4'hA) follows STABLE_CYCLES samples later.
- Illegal and blank: digit 3 driven with 7'h7E (only A lit) -> upd_err=1, digit_valid[3]=0. Then 7'h7F -> upd_blank=1, and hex_flat[15:12] keeps its prior value.
- Multi-enable and reset: dig_en_n=4'b1100 held 20 cycles -> no upd_valid. Then assert rst_n mid-run at counter=2 -> outputs clear immediately, with no spurious pulse after release.
